// File: rtl/hold_reg_ctl.sv
`default_nettype none
// ============================================================================
// Module   : hold_reg_ctl
// Purpose  : Per-port request capture stage of calc1, upstream of the priority
//            block. Each of the four requester ports has its own FSM
//            (IDLE -> OP2 -> ISSUE -> WAIT -> IDLE). The FSM captures cmd and
//            operand1 in one cycle and operand2 in the next. It then drives a
//            one-cycle prio request, holds both operands for the ALUs, and
//            blocks the port until resp_done.
// Ports    : c_clk, reset (sync, active-low)
//            reqN_cmd_in / reqN_data_in  - port N command and data (N=1..4)
//            resp_done[N-1]              - response for port N delivered
//            holdN_prio_req              - one-cycle command to priority
//            holdN_data1 / holdN_data2   - captured operands for port N
//            port_busy, cmd_err, wd_timeout - per-port status / pulses
// Config   : define HOLD_TIMEOUT_EN to enable the WAIT-state watchdog
//            (limit TIMEOUT_CYC); otherwise wd_timeout is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hold_reg_ctl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  input  logic [3:0]        resp_done,
  output logic [3:0]        hold1_prio_req,
  output logic [3:0]        hold2_prio_req,
  output logic [3:0]        hold3_prio_req,
  output logic [3:0]        hold4_prio_req,
  output logic [DATA_W-1:0] hold1_data1,
  output logic [DATA_W-1:0] hold2_data1,
  output logic [DATA_W-1:0] hold3_data1,
  output logic [DATA_W-1:0] hold4_data1,
  output logic [DATA_W-1:0] hold1_data2,
  output logic [DATA_W-1:0] hold2_data2,
  output logic [DATA_W-1:0] hold3_data2,
  output logic [DATA_W-1:0] hold4_data2,
  output logic [3:0]        port_busy,
  output logic [3:0]        cmd_err,
  output logic [3:0]        wd_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OP2   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Per-port views of the flat port list so one generate body serves all ports
  logic [3:0]        w_cmd  [4];
  logic [DATA_W-1:0] w_data [4];
  logic [3:0]        w_prio [4];
  logic [DATA_W-1:0] w_d1   [4];
  logic [DATA_W-1:0] w_d2   [4];

  assign w_cmd[0]  = req1_cmd_in;
  assign w_cmd[1]  = req2_cmd_in;
  assign w_cmd[2]  = req3_cmd_in;
  assign w_cmd[3]  = req4_cmd_in;
  assign w_data[0] = req1_data_in;
  assign w_data[1] = req2_data_in;
  assign w_data[2] = req3_data_in;
  assign w_data[3] = req4_data_in;

  assign hold1_prio_req = w_prio[0];
  assign hold2_prio_req = w_prio[1];
  assign hold3_prio_req = w_prio[2];
  assign hold4_prio_req = w_prio[3];
  assign hold1_data1    = w_d1[0];
  assign hold2_data1    = w_d1[1];
  assign hold3_data1    = w_d1[2];
  assign hold4_data1    = w_d1[3];
  assign hold1_data2    = w_d2[0];
  assign hold2_data2    = w_d2[1];
  assign hold3_data2    = w_d2[2];
  assign hold4_data2    = w_d2[3];

`ifdef HOLD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC != 0);
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_port
    state_e            state_q;
    logic [3:0]        cmd_q;
    logic [3:0]        prio_q;
    logic [DATA_W-1:0] data1_q;
    logic [DATA_W-1:0] data2_q;
    logic              err_q;
    logic              w_legal;
    logic              w_nonzero;

    assign w_nonzero = (w_cmd[gi] != 4'd0);
    assign w_legal   = (w_cmd[gi] == 4'd1) || (w_cmd[gi] == 4'd2) ||
                       (w_cmd[gi] == 4'd5) || (w_cmd[gi] == 4'd6);

`ifdef HOLD_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             wdt_q;
    logic             w_expire;
    // cnt_q counts completed WAIT cycles, so the limit is hit on the
    // TIMEOUT_CYC-th WAIT cycle.
    assign w_expire      = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign wd_timeout[gi] = wdt_q;
`else
    assign wd_timeout[gi] = 1'b0;
`endif

    always_ff @(posedge c_clk) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        cmd_q   <= 4'd0;
        prio_q  <= 4'd0;
        data1_q <= '0;
        data2_q <= '0;
        err_q   <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
        cnt_q   <= '0;
        wdt_q   <= 1'b0;
`endif
      end else begin
        // Pulse outputs default low; prio_q is only set on OP2 -> ISSUE.
        err_q  <= 1'b0;
        prio_q <= 4'd0;
`ifdef HOLD_TIMEOUT_EN
        wdt_q  <= 1'b0;
`endif
        case (state_q)
          ST_IDLE: begin
            if (w_legal) begin
              cmd_q   <= w_cmd[gi];
              data1_q <= w_data[gi];
              state_q <= ST_OP2;
            end else if (w_nonzero) begin
              err_q <= 1'b1;
            end
          end
          ST_OP2: begin
            data2_q <= w_data[gi];
            prio_q  <= cmd_q;
            state_q <= ST_ISSUE;
            err_q   <= w_nonzero;
          end
          ST_ISSUE: begin
            state_q <= ST_WAIT;
            err_q   <= w_nonzero;
`ifdef HOLD_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
          ST_WAIT: begin
            if (resp_done[gi]) begin
              // Done frees the port in this very cycle, so a command arriving
              // alongside it is treated as if seen in IDLE.
              if (w_legal) begin
                cmd_q   <= w_cmd[gi];
                data1_q <= w_data[gi];
                state_q <= ST_OP2;
              end else begin
                state_q <= ST_IDLE;
                err_q   <= w_nonzero;
              end
            end else begin
              err_q <= w_nonzero;
`ifdef HOLD_TIMEOUT_EN
              if (w_expire) begin
                state_q <= ST_IDLE;
                wdt_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
`endif
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    assign port_busy[gi] = (state_q != ST_IDLE);
    assign cmd_err[gi]   = err_q;
    assign w_prio[gi]    = prio_q;
    assign w_d1[gi]      = data1_q;
    assign w_d2[gi]      = data2_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_hold_reg_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hold_reg_ctl
// Purpose  : Self-checking bench for hold_reg_ctl. A cycle-count based
//            reference model predicts every output after each clock edge;
//            directed scenarios add explicit spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hold_reg_ctl;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 4;

  logic              c_clk = 1'b0;
  logic              reset;
  logic [3:0]        req_cmd  [4];
  logic [DATA_W-1:0] req_data [4];
  logic [3:0]        resp_done;
  logic [3:0]        hold_prio [4];
  logic [DATA_W-1:0] hold_d1   [4];
  logic [DATA_W-1:0] hold_d2   [4];
  logic [3:0]        port_busy, cmd_err, wd_timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a port is "active" from the cycle its command is
  // accepted (m_acc) until done/timeout; its phase is the cycle distance.
  bit                m_active [4];
  int                m_acc    [4];
  logic [3:0]        m_cmd    [4];
  logic [DATA_W-1:0] m_d1     [4];
  logic [DATA_W-1:0] m_d2     [4];
  logic [3:0]        e_prio   [4];
  logic [3:0]        e_err = 4'd0;
  logic [3:0]        e_wdt = 4'd0;

  always #5 c_clk = ~c_clk;

  hold_reg_ctl #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(req_cmd[0]), .req2_cmd_in(req_cmd[1]),
    .req3_cmd_in(req_cmd[2]), .req4_cmd_in(req_cmd[3]),
    .req1_data_in(req_data[0]), .req2_data_in(req_data[1]),
    .req3_data_in(req_data[2]), .req4_data_in(req_data[3]),
    .resp_done(resp_done),
    .hold1_prio_req(hold_prio[0]), .hold2_prio_req(hold_prio[1]),
    .hold3_prio_req(hold_prio[2]), .hold4_prio_req(hold_prio[3]),
    .hold1_data1(hold_d1[0]), .hold2_data1(hold_d1[1]),
    .hold3_data1(hold_d1[2]), .hold4_data1(hold_d1[3]),
    .hold1_data2(hold_d2[0]), .hold2_data2(hold_d2[1]),
    .hold3_data2(hold_d2[2]), .hold4_data2(hold_d2[3]),
    .port_busy(port_busy), .cmd_err(cmd_err), .wd_timeout(wd_timeout)
  );

  function automatic bit is_legal(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  function automatic void model_update();
    e_err = 4'd0;
    e_wdt = 4'd0;
    for (int p = 0; p < 4; p++) e_prio[p] = 4'd0;
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        m_active[p] = 1'b0;
        m_d1[p]     = '0;
        m_d2[p]     = '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        int         rel;
        logic [3:0] c;
        bit         free;
        rel  = cyc - m_acc[p];
        c    = req_cmd[p];
        free = !m_active[p];
        if (m_active[p]) begin
          if (rel == 1) begin
            m_d2[p]   = req_data[p];
            e_prio[p] = m_cmd[p];
            e_err[p]  = (c != 4'd0);
          end else if (rel == 2) begin
            e_err[p] = (c != 4'd0);
          end else if (resp_done[p]) begin
            m_active[p] = 1'b0;
            free        = 1'b1;
          end else begin
            e_err[p] = (c != 4'd0);
`ifdef HOLD_TIMEOUT_EN
            // rel-2 = number of WAIT cycles including this one
            if (rel - 2 == TIMEOUT_CYC) begin
              m_active[p] = 1'b0;
              e_wdt[p]    = 1'b1;
            end
`endif
          end
        end
        if (free && c != 4'd0) begin
          if (is_legal(c)) begin
            m_active[p] = 1'b1;
            m_acc[p]    = cyc;
            m_cmd[p]    = c;
            m_d1[p]     = req_data[p];
          end else begin
            e_err[p] = 1'b1;
          end
        end
      end
    end
    cyc++;
  endfunction

  function automatic logic [27:0] act_ctrl();
    return {hold_prio[0], hold_prio[1], hold_prio[2], hold_prio[3], port_busy, cmd_err, wd_timeout};
  endfunction
  function automatic logic [27:0] exp_ctrl();
    return {e_prio[0], e_prio[1], e_prio[2], e_prio[3],
            {m_active[3], m_active[2], m_active[1], m_active[0]}, e_err, e_wdt};
  endfunction
  function automatic logic [8*DATA_W-1:0] act_data();
    return {hold_d1[0], hold_d1[1], hold_d1[2], hold_d1[3], hold_d2[0], hold_d2[1], hold_d2[2], hold_d2[3]};
  endfunction
  function automatic logic [8*DATA_W-1:0] exp_data();
    return {m_d1[0], m_d1[1], m_d1[2], m_d1[3], m_d2[0], m_d2[1], m_d2[2], m_d2[3]};
  endfunction

  task automatic step();
    @(posedge c_clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 4; p++) begin
      req_cmd[p]  = 4'd0;
      req_data[p] = '0;
    end
    resp_done = 4'd0;
  endtask

  task automatic start_clean();
    clear_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 4; p++) begin
        req_cmd[p]  = 4'(1 + p);
        req_data[p] = $urandom;
      end
      resp_done = 4'hF;
      step();
      total++;
      if (act_ctrl() !== 28'd0 || act_data() !== '0) begin
        bad++;
        $display("FAIL reset_zero cyc=%0d ctrl=%h data=%h want all zero", cyc, act_ctrl(), act_data());
      end
    end
    reset = 1'b1;
    clear_inputs();
  endtask

  task automatic test_basic();
    int cmds [7] = '{1, 0, 0, 0, 0, 0, 0};
    int dats [7] = '{5, 3, 32'h0000_dead, 7, 8, 9, 10};
    int dons [7] = '{0, 0, 0, 0, 0, 1, 0};
    start_clean();
    for (int i = 0; i < 7; i++) begin
      req_cmd[0]  = 4'(cmds[i]);
      req_data[0] = DATA_W'(dats[i]);
      resp_done   = {3'b000, 1'(dons[i])};
      step();
      total++;
      if (act_ctrl() !== exp_ctrl()) begin
        bad++;
        $display("FAIL basic_ctrl cyc=%0d got=%h exp=%h", cyc, act_ctrl(), exp_ctrl());
      end
      total++;
      if (act_data() !== exp_data()) begin
        bad++;
        $display("FAIL basic_data cyc=%0d got=%h exp=%h", cyc, act_data(), exp_data());
      end
      if (i == 1) begin
        total++;
        if (hold_prio[0] !== 4'd1 || hold_d1[0] !== 32'd5 || hold_d2[0] !== 32'd3) begin
          bad++;
          $display("FAIL basic_issue prio=%0d d1=%h d2=%h want 1/5/3", hold_prio[0], hold_d1[0], hold_d2[0]);
        end
      end
      if (i == 2 || i == 4) begin
        total++;
        if (hold_prio[0] !== 4'd0 || port_busy[0] !== 1'b1) begin
          bad++;
          $display("FAIL basic_wait prio=%0d busy=%b want 0/1", hold_prio[0], port_busy[0]);
        end
      end
      if (i == 5) begin
        total++;
        if (port_busy[0] !== 1'b0) begin
          bad++;
          $display("FAIL basic_done busy=%b want 0", port_busy[0]);
        end
      end
    end
  endtask

  task automatic test_all_ports();
    start_clean();
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 4; p++) begin
        req_cmd[p]  = (i == 0) ? 4'd5 : 4'd0;
        req_data[p] = $urandom;
      end
      resp_done = (i == 4) ? 4'hF : 4'h0;
      step();
      total++;
      if (act_ctrl() !== exp_ctrl() || act_data() !== exp_data()) begin
        bad++;
        $display("FAIL all_ports cyc=%0d ctrl=%h exp=%h", cyc, act_ctrl(), exp_ctrl());
      end
      if (i == 1) begin
        total++;
        if ({hold_prio[0], hold_prio[1], hold_prio[2], hold_prio[3]} !== 16'h5555 || cmd_err !== 4'd0) begin
          bad++;
          $display("FAIL all_ports_issue prio=%h err=%b want 5555/0000",
                   {hold_prio[0], hold_prio[1], hold_prio[2], hold_prio[3]}, cmd_err);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int cmds [4] = '{3, 9, 0, 0};
    start_clean();
    for (int i = 0; i < 4; i++) begin
      req_cmd[1]  = 4'(cmds[i]);
      req_data[1] = $urandom;
      step();
      total++;
      if (act_ctrl() !== exp_ctrl() || act_data() !== exp_data()) begin
        bad++;
        $display("FAIL illegal cyc=%0d ctrl=%h exp=%h", cyc, act_ctrl(), exp_ctrl());
      end
      total++;
      if (cmd_err[1] !== (i < 2) || hold_prio[1] !== 4'd0 || port_busy[1] !== 1'b0) begin
        bad++;
        $display("FAIL illegal_port2 i=%0d err=%b prio=%0d busy=%b", i, cmd_err[1], hold_prio[1], port_busy[1]);
      end
    end
  endtask

  task automatic test_wait_cmd();
    int cmds [9] = '{1, 0, 0, 2, 6, 0, 0, 0, 0};
    int dons [9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
    int dats [9] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88, 32'h99};
    start_clean();
    for (int i = 0; i < 9; i++) begin
      req_cmd[2]  = 4'(cmds[i]);
      req_data[2] = DATA_W'(dats[i]);
      resp_done   = {1'b0, 1'(dons[i]), 2'b00};
      step();
      total++;
      if (act_ctrl() !== exp_ctrl() || act_data() !== exp_data()) begin
        bad++;
        $display("FAIL wait_cmd cyc=%0d ctrl=%h exp=%h", cyc, act_ctrl(), exp_ctrl());
      end
      if (i == 3) begin
        total++;
        if (cmd_err[2] !== 1'b1 || hold_d1[2] !== 32'h11 || port_busy[2] !== 1'b1) begin
          bad++;
          $display("FAIL wait_drop err=%b d1=%h busy=%b want 1/11/1", cmd_err[2], hold_d1[2], port_busy[2]);
        end
      end
      if (i == 5) begin
        total++;
        if (hold_prio[2] !== 4'd6 || hold_d1[2] !== 32'h55 || hold_d2[2] !== 32'h66) begin
          bad++;
          $display("FAIL wait_b2b prio=%0d d1=%h d2=%h want 6/55/66", hold_prio[2], hold_d1[2], hold_d2[2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cmds [7] = '{1, 0, 1, 0, 0, 0, 0};
    int rsts [7] = '{1, 0, 1, 1, 1, 1, 1};
    start_clean();
    for (int i = 0; i < 7; i++) begin
      req_cmd[3]  = 4'(cmds[i]);
      req_data[3] = $urandom;
      reset       = 1'(rsts[i]);
      resp_done   = (i == 5) ? 4'h8 : 4'h0;
      step();
      total++;
      if (act_ctrl() !== exp_ctrl() || act_data() !== exp_data()) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d ctrl=%h exp=%h", cyc, act_ctrl(), exp_ctrl());
      end
      if (i == 1) begin
        total++;
        if (act_ctrl() !== 28'd0 || act_data() !== '0) begin
          bad++;
          $display("FAIL reset_mid_zero ctrl=%h want 0", act_ctrl());
        end
      end
      if (i == 3) begin
        total++;
        if (hold_prio[3] !== 4'd1) begin
          bad++;
          $display("FAIL reset_mid_issue prio=%0d want 1", hold_prio[3]);
        end
      end
    end
    reset = 1'b1;
  endtask

`ifdef HOLD_TIMEOUT_EN
  task automatic test_timeout();
    start_clean();
    for (int i = 0; i < 9; i++) begin
      req_cmd[0]  = (i == 0) ? 4'd2 : ((i == 7) ? 4'd1 : 4'd0);
      req_data[0] = $urandom;
      step();
      total++;
      if (act_ctrl() !== exp_ctrl() || act_data() !== exp_data()) begin
        bad++;
        $display("FAIL timeout cyc=%0d ctrl=%h exp=%h", cyc, act_ctrl(), exp_ctrl());
      end
      total++;
      if (wd_timeout[0] !== (i == 6) || port_busy[0] !== (i != 6)) begin
        bad++;
        $display("FAIL timeout_pulse i=%0d wdt=%b busy=%b", i, wd_timeout[0], port_busy[0]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int legal   [4] = '{1, 2, 5, 6};
    int illegal [6] = '{3, 4, 7, 8, 9, 15};
    start_clean();
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 4; p++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 5)      req_cmd[p] = 4'd0;
        else if (r < 8) req_cmd[p] = 4'(legal[$urandom_range(0, 3)]);
        else            req_cmd[p] = 4'(illegal[$urandom_range(0, 5)]);
        req_data[p] = $urandom;
      end
      resp_done = 4'($urandom) & 4'($urandom);
      reset     = ($urandom_range(0, 99) != 0);
      step();
      total++;
      if (act_ctrl() !== exp_ctrl()) begin
        bad++;
        $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", cyc, act_ctrl(), exp_ctrl());
      end
      total++;
      if (act_data() !== exp_data()) begin
        bad++;
        $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, act_data(), exp_data());
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_basic();
    test_all_ports();
    test_illegal();
    test_wait_cmd();
    test_reset_mid();
`ifdef HOLD_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
